// File: rtl/spi_frame_decoder_if.sv
// -----------------------------------------------------------------------------
// spi_frame_decoder_if
//
// Bundles the SPI pins and the decoded-frame outputs of spi_frame_decoder.
//
// Signals:
//   sclk, copi, ncs   SPI pins, asynchronous to the decoder clock
//   valid             one-cycle pulse: a complete frame was decoded
//   read_write        frame bit 15 (1 = write)
//   addr[6:0]         frame bits 14:8
//   data[7:0]         frame bits 7:0
//   frame_err         one-cycle pulse on a malformed frame
//
// Modports:
//   master  the decoder: samples the pins, drives the decoded-frame outputs
//   slave   the pin driver / frame consumer side
// -----------------------------------------------------------------------------
interface spi_frame_decoder_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       valid;
    logic       read_write;
    logic [6:0] addr;
    logic [7:0] data;
    logic       frame_err;

    modport master (
        input  sclk,
        input  copi,
        input  ncs,
        output valid,
        output read_write,
        output addr,
        output data,
        output frame_err
    );

    modport slave (
        output sclk,
        output copi,
        output ncs,
        input  valid,
        input  read_write,
        input  addr,
        input  data,
        input  frame_err
    );
endinterface

// File: rtl/spi_frame_decoder.sv
// -----------------------------------------------------------------------------
// spi_frame_decoder
//
// Samples the asynchronous SPI pins into the clk domain and deserialises
// 16-bit mode-0 frames, MSB first. A well-formed frame (exactly 16 SCLK rises
// between nCS fall and nCS rise) produces a one-cycle valid pulse and loads
// read_write/addr/data, which then hold until the next good frame.
//
// Parameters:
//   SYNC_STAGES   flops per pin synchroniser (2..3)
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   bus           spi_frame_decoder_if.master (pins in, decoded frame out)
//
// Build option:
//   SPI_FRAME_ERR_EN  when defined, frame_err pulses for one cycle whenever
//                     nCS rises with a bit count other than 16; otherwise
//                     frame_err is tied low and the check is not built.
// -----------------------------------------------------------------------------
module spi_frame_decoder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_frame_decoder_if.master bus
);

    localparam logic [0:0] StIdle     = 1'b0;
    localparam logic [0:0] StActive   = 1'b1;
    localparam logic [4:0] FullCount  = 5'd16;
    localparam logic [4:0] SatCount   = 5'd17;
    // Cycles after reset until the ncs history flop holds a real pin sample.
    localparam logic [2:0] PrimeCount = 3'(SYNC_STAGES + 1);

    // Synchronisers and history flops
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_hist_q;
    logic                   copi_hist_q;
    logic                   ncs_hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            copi_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            copi_hist_q <= copi_sync_q[SYNC_STAGES-1];
            ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge detection
    logic sclk_rise;
    logic ncs_rise;
    logic ncs_fall;

    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
    assign ncs_rise  = ncs_sync_q[SYNC_STAGES-1] & ~ncs_hist_q;
    assign ncs_fall  = ~ncs_sync_q[SYNC_STAGES-1] & ncs_hist_q;

    // Events are registered once; copi_hist_q and ncs_hist_q are then the
    // synchronised pin levels from the cycle in which each event was seen.
    logic sclk_rise_q;
    logic ncs_rise_q;
    logic ncs_fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_rise_q <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
        end else begin
            sclk_rise_q <= sclk_rise;
            ncs_rise_q  <= ncs_rise;
            ncs_fall_q  <= ncs_fall;
        end
    end

    // The ncs chain resets high, so a pin already low at reset release looks
    // like a fall. Frames are only accepted once a genuine high level has
    // propagated through the whole chain after reset.
    logic [2:0] prime_cnt_q;
    logic       armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            if (prime_cnt_q != PrimeCount) begin
                prime_cnt_q <= prime_cnt_q + 3'd1;
            end
            if (prime_cnt_q == PrimeCount && ncs_hist_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Frame FSM
    logic [0:0]  state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  count_q, count_d;
    logic        valid_d;
    logic        bad_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        valid_d = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (ncs_fall_q && armed_q) begin
                    shift_d = '0;
                    count_d = '0;
                    state_d = StActive;
                end
            end
            StActive: begin
                // nCS rise takes priority over a coincident SCLK rise.
                if (ncs_rise_q) begin
                    state_d = StIdle;
                    if (count_q == FullCount) begin
                        valid_d = 1'b1;
                    end else begin
                        bad_d = 1'b1;
                    end
                end else if (sclk_rise_q && !ncs_hist_q) begin
                    shift_d = {shift_q[14:0], copi_hist_q};
                    if (count_q != SatCount) begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // Output registers
    logic       valid_q;
    logic       read_write_q;
    logic [6:0] addr_q;
    logic [7:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            read_write_q <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            valid_q <= valid_d;
            if (valid_d) begin
                read_write_q <= shift_q[15];
                addr_q       <= shift_q[14:8];
                data_q       <= shift_q[7:0];
            end
        end
    end

    assign bus.valid      = valid_q;
    assign bus.read_write = read_write_q;
    assign bus.addr       = addr_q;
    assign bus.data       = data_q;

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= bad_d;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    // Malformed frames are dropped silently; bad_d only steers the FSM.
    logic unused_bad;
    assign unused_bad    = bad_d;
    assign bus.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_decoder.sv
`timescale 1ns/1ps
module tb_spi_frame_decoder;

    localparam int unsigned S = 3;
`ifdef SPI_FRAME_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    spi_frame_decoder_if bus ();

    spi_frame_decoder #(
        .SYNC_STAGES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor: counts pulses, records decoded fields, watches field hold.
    int          n_valid = 0;
    int          n_err = 0;
    int          hold_viol = 0;
    logic [15:0] prev_fields = '0;
    logic [15:0] got_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fields <= '0;
        end else begin
            if (bus.valid === 1'b1) begin
                n_valid <= n_valid + 1;
                got_q.push_back({bus.read_write, bus.addr, bus.data});
            end else if ({bus.read_write, bus.addr, bus.data} !== prev_fields) begin
                hold_viol <= hold_viol + 1;
            end
            if (bus.frame_err === 1'b1) n_err <= n_err + 1;
            prev_fields <= {bus.read_write, bus.addr, bus.data};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Reference state: fields of the last well-formed frame.
    logic [15:0] model_fields = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            bus.copi = v[i];
            cyc(half);
            bus.sclk = 1'b1;
            cyc(half);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] v, input int n, input int half);
        bus.ncs = 1'b0;
        cyc(half);
        send_bits(v, n, half);
        cyc(half);
        bus.ncs = 1'b1;
    endtask

    // A frame of n bits is good exactly when n == 16; then its fields are v[15:0].
    task automatic expect_frame(input string tag, input logic [31:0] v, input int n,
                                input int v0, input int e0);
        bit good;
        good = (n == 16);
        check({tag, ".valid_count"}, 32'(n_valid - v0), good ? 32'd1 : 32'd0);
        check({tag, ".err_count"}, 32'(n_err - e0), (!good && ErrEn) ? 32'd1 : 32'd0);
        if (good) begin
            model_fields = v[15:0];
            if (got_q.size() == 0) begin
                check({tag, ".decoded"}, 32'hDEAD_0000, {16'd0, v[15:0]});
            end else begin
                check({tag, ".decoded"}, {16'd0, got_q[0]}, {16'd0, v[15:0]});
            end
        end
        check({tag, ".fields"}, {16'd0, bus.read_write, bus.addr, bus.data},
              {16'd0, model_fields});
        got_q.delete();
    endtask

    initial begin
        int v0, e0, n, half, r;
        logic [31:0] v;

        rst_n    = 1'b0;
        bus.ncs  = 1'b1;
        bus.sclk = 1'b0;
        bus.copi = 1'b0;
        cyc(5);
        check("reset_outputs", {bus.valid, bus.read_write, bus.addr, bus.data, bus.frame_err},
              32'd0);
        rst_n = 1'b1;
        cyc(10);
        check("post_reset_outputs",
              {bus.valid, bus.read_write, bus.addr, bus.data, bus.frame_err}, 32'd0);

        // Write frame, SCLK period 8
        v0 = n_valid; e0 = n_err;
        frame(32'h80A5, 16, 4); cyc(12);
        expect_frame("write_80A5", 32'h80A5, 16, v0, e0);

        // Read frame, then idle hold
        v0 = n_valid; e0 = n_err;
        frame(32'h0412, 16, 4); cyc(12);
        expect_frame("read_0412", 32'h0412, 16, v0, e0);
        cyc(100);
        check("hold_100.fields", {16'd0, bus.read_write, bus.addr, bus.data}, 32'h0412);
        check("hold_100.viol", 32'(hold_viol), 32'd0);

        // Short and long frames
        v0 = n_valid; e0 = n_err;
        frame(32'h5A5A, 15, 4); cyc(12);
        expect_frame("short_15", 32'h5A5A, 15, v0, e0);
        v0 = n_valid; e0 = n_err;
        frame(32'h1_8123, 17, 4); cyc(12);
        expect_frame("long_17", 32'h1_8123, 17, v0, e0);

        // Reset mid-frame with ncs held low across release
        v0 = n_valid; e0 = n_err;
        bus.ncs = 1'b0;
        cyc(4);
        send_bits(32'h81FF >> 7, 9, 4);
        cyc(2);
        rst_n = 1'b0;
        cyc(3);
        check("midreset_outputs",
              {bus.valid, bus.read_write, bus.addr, bus.data, bus.frame_err}, 32'd0);
        rst_n = 1'b1;
        send_bits(32'h81FF & 32'h7F, 7, 4);
        cyc(4);
        bus.ncs = 1'b1;
        cyc(12);
        model_fields = '0;
        check("midreset.valid_count", 32'(n_valid - v0), 32'd0);
        check("midreset.err_count", 32'(n_err - e0), 32'd0);
        check("midreset.fields",
              {bus.valid, bus.read_write, bus.addr, bus.data, bus.frame_err}, 32'd0);
        got_q.delete();
        cyc(4);
        v0 = n_valid; e0 = n_err;
        frame(32'h8233, 16, 4); cyc(12);
        expect_frame("after_reset_8233", 32'h8233, 16, v0, e0);

        // Back-to-back frames with minimum nCS gap
        v0 = n_valid; e0 = n_err;
        frame(32'h8011, 16, 4);
        cyc(S + 1);
        frame(32'h8122, 16, 4);
        cyc(12);
        check("b2b.valid_count", 32'(n_valid - v0), 32'd2);
        check("b2b.err_count", 32'(n_err - e0), 32'd0);
        check("b2b.first", (got_q.size() > 0) ? {16'd0, got_q[0]} : 32'hDEAD_0000, 32'h8011);
        check("b2b.second", (got_q.size() > 1) ? {16'd0, got_q[1]} : 32'hDEAD_0000, 32'h8122);
        model_fields = 16'h8122;
        got_q.delete();

        // Latency: ncs goes high just after an edge; the next edge is the first
        // to sample it, and valid must appear on the (S+2)-th edge counting that one.
        v0 = n_valid; e0 = n_err;
        frame(32'hC3E7, 16, 4);
        repeat (S + 1) @(posedge clk);
        @(negedge clk);
        check("latency.early", {31'd0, bus.valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("latency.on_time", {31'd0, bus.valid}, 32'd1);
        cyc(10);
        expect_frame("latency_C3E7", 32'hC3E7, 16, v0, e0);

        // Randomized frames against the model
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 7);
            if (r <= 4)      n = 16;
            else if (r == 5) n = 15;
            else if (r == 6) n = 17;
            else             n = $urandom_range(0, 20);
            half = $urandom_range(4, 6);
            v = $urandom;
            v0 = n_valid; e0 = n_err;
            frame(v, n, half);
            cyc(12 + $urandom_range(0, 6));
            expect_frame($sformatf("rand%0d_n%0d", k, n), v & ((32'd1 << n) - 32'd1), n, v0, e0);
        end

        check("final.hold_viol", 32'(hold_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_decoder.md
# spi_frame_decoder

Front end of the SPI configuration path. Samples the asynchronous SPI pins (SCLK, COPI, nCS) into the `clk` domain and deserialises 16-bit mode-0 frames MSB first. Each well-formed frame becomes a one-cycle `valid` pulse carrying `read_write`, `addr` and `data`. These outputs connect directly to the register-bank stage's `valid`, `read_write`, `addr` and `data` inputs.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in each pin synchroniser; legal range 2–3.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low; one clock domain (`clk`) only.
- `sclk`  in  1  SPI clock pin, asynchronous to `clk`.
- `copi`  in  1  SPI data pin, asynchronous to `clk`.
- `ncs`  in  1  SPI chip select pin, active-low, asynchronous to `clk`.
- `valid`  out  1  one-cycle pulse: a complete frame was decoded.
- `read_write`  out  1  frame bit 15; 1 = write.
- `addr`  out  7  frame bits 14:8.
- `data`  out  8  frame bits 7:0.
- `frame_err`  out  1  one-cycle pulse on a malformed frame (see Configuration).

## Operation
- Synchronisers:
  - Each pin passes through `SYNC_STAGES` flops, then one history flop for edge detection.
  - Reset values: `ncs` chain 1; `sclk` and `copi` chains 0.
- Edge detection, using synchronised values:
  - sclk_rise = sync 1 and history 0.
  - ncs_fall and ncs_rise are defined the same way.
- FSM, two states; reset state IDLE.
  - IDLE:
    - On ncs_fall: clear the 16-bit shift register, clear the 5-bit bit counter, go to ACTIVE.
    - All other events are ignored.
  - ACTIVE:
    - On sclk_rise while synchronised `ncs` = 0: shift register <= {shift[14:0], copi_sync}.
    - The counter increments on the same event and saturates at 17.
    - On ncs_rise: go to IDLE.
      - If counter == 16: pulse `valid` and load the outputs.
      - Otherwise: pulse `frame_err` (if compiled in) and leave the outputs unchanged.
- Output fields are registers and hold the last good frame until the next `valid`.
- Reset value of every output is 0.
- A reset mid-frame discards the partial frame and returns the FSM to IDLE. If `ncs` is already low when reset is released, no frame starts until `ncs` goes high and then low again.

## Timing
- `valid`, `read_write`, `addr` and `data` update on the same `clk` edge.
- `valid` is high for exactly one cycle.
- Latency: `valid` rises SYNC_STAGES+2 `clk` edges after the first edge that samples `ncs` high at the pin.
- No backpressure. The downstream register bank accepts every `valid`.
- Input constraints:
  - SCLK high time and low time ≥ SYNC_STAGES+1 `clk` periods each.
  - COPI stable from SCLK rise −1 to +SYNC_STAGES+1 `clk` periods.
  - nCS high time between frames ≥ SYNC_STAGES+1 `clk` periods.
- Simultaneous events in the synchronised domain:
  - sclk_rise in the same cycle as ncs_rise: ncs_rise wins and the bit is not shifted.
  - ncs_fall in the same cycle as sclk_rise while in IDLE: the clear wins and the bit is not shifted.
- Counter saturation: 17 or more SCLK rises make a frame malformed. The counter does not wrap back to 16.

## Configuration
- Macro `SPI_FRAME_ERR_EN`.
- Defined: `frame_err` pulses for one cycle, on the same edge `valid` would have used, whenever ncs_rise occurs with counter ≠ 16. This includes 0-bit frames.
- Undefined: `frame_err` is tied to 0 and the check logic is not built. Malformed frames are still silently dropped (no `valid`).

## Test plan
- Write frame 16'h80A5, SCLK period 8 `clk` → exactly one `valid` pulse; `read_write`=1, `addr`=7'h00, `data`=8'hA5; `frame_err`=0.
- Read frame 16'h0412 → `valid` pulse; `read_write`=0, `addr`=7'h04, `data`=8'h12. Fields then hold these values for 100 idle cycles.
- 15-bit frame, then a separate 17-bit frame → no `valid`; outputs keep their previous values. With `SPI_FRAME_ERR_EN`, `frame_err` pulses once per frame; without it, `frame_err` stays 0.
- Assert `rst_n` low after bit 9 of frame 16'h81FF, release it with `ncs` still low, finish the frame → no `valid`. All outputs read 0 from reset onward. The next full frame 16'h8233 decodes correctly.
- Back-to-back frames 16'h8011 and 16'h8122 with `ncs` high for SYNC_STAGES+1 cycles between them → two `valid` pulses, in order, with the correct fields.
- Latency check with `SYNC_STAGES`=3 → `valid` occurs 5 `clk` edges after `ncs` is first sampled high.
